// File: rtl/full_bias_add_ctrl.sv
// Bias-add sequencer for one fully-connected layer: accumulator stream in, bias RAM read, shared
// registered adder, output FIFO with last marker. Optional bias bypass via FULL_BIAS_BYPASS_EN.
module full_bias_add_ctrl #(
   parameter int CNT_W     = 10,
   parameter int OUT_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_num_out,
`ifdef FULL_BIAS_BYPASS_EN
   input  logic             cfg_bypass,
`endif
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             bias_rd_en,
   output logic [CNT_W-1:0] bias_rd_addr,
   input  logic [31:0]      bias_rd_data,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last
);

   localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int FCNT_W = $clog2(OUT_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q, num_q;
   logic              s1Valid_q, s1Last_q, s2Valid_q, s2Last_q;
   logic [31:0]       s1Data_q;
   logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
   logic [FCNT_W-1:0] fifoCount_q;
   logic [31:0]       fifoData [OUT_DEPTH];
   logic              fifoLast [OUT_DEPTH];

   logic              bypassEn;
   logic              accept, isLast, creditOk, drainEmpty, push, pop;
   logic [FCNT_W:0]   inflight;
   logic [31:0]       pushData;

   // Credit uses only registered occupancy so out_ready never reaches in_ready combinationally.
   assign inflight   = {1'b0, fifoCount_q} + (FCNT_W+1)'(s1Valid_q) + (FCNT_W+1)'(s2Valid_q);
   assign creditOk   = inflight < (FCNT_W+1)'(OUT_DEPTH);
   assign isLast     = (cnt_q == num_q - CNT_W'(1));
   assign accept     = in_ready & in_valid;
   assign push       = s2Valid_q;
   assign pop        = out_valid & out_ready;
   assign drainEmpty = !s1Valid_q && !s2Valid_q &&
                       ((fifoCount_q == '0) || (fifoCount_q == FCNT_W'(1) && pop));

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (cfg_num_out != '0) ? RUN : DONE;
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = creditOk;
            if (in_valid && creditOk && isLast) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drainEmpty) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         num_q     <= '0;
         s1Valid_q <= 1'b0;
         s1Last_q  <= 1'b0;
         s1Data_q  <= '0;
         s2Valid_q <= 1'b0;
         s2Last_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            cnt_q <= '0;
            num_q <= cfg_num_out;
         end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         s1Valid_q <= accept;
         if (accept) begin
            s1Data_q <= in_data;
            s1Last_q <= isLast;
         end
         s2Valid_q <= s1Valid_q;
         s2Last_q  <= s1Last_q;
      end
   end

`ifdef FULL_BIAS_BYPASS_EN
   logic        bypass_q;
   logic [31:0] s2Data_q;

   // In bypass the stage-1 word rides a matching register so latency equals the adder path.
   always_ff @(posedge clk) begin
      if (reset) begin
         bypass_q <= 1'b0;
         s2Data_q <= '0;
      end else begin
         if (state_q == IDLE && start) bypass_q <= cfg_bypass;
         s2Data_q <= s1Data_q;
      end
   end

   assign bypassEn = bypass_q;
   assign pushData = bypass_q ? s2Data_q : add_result;
`else
   assign bypassEn = 1'b0;
   assign pushData = add_result;
`endif

   assign bias_rd_en   = accept & !bypassEn;
   assign bias_rd_addr = cnt_q;
   assign add_a        = bypassEn ? 32'h0 : s1Data_q;
   assign add_b        = bypassEn ? 32'h0 : bias_rd_data;

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
      end else begin
         if (push) wrPtr_q <= ptrInc(wrPtr_q);
         if (pop)  rdPtr_q <= ptrInc(rdPtr_q);
         case ({push, pop})
            2'b10:   fifoCount_q <= fifoCount_q + FCNT_W'(1);
            2'b01:   fifoCount_q <= fifoCount_q - FCNT_W'(1);
            default: fifoCount_q <= fifoCount_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifoData[wrPtr_q] <= pushData;
         fifoLast[wrPtr_q] <= s2Last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) assert (fifoCount_q != FCNT_W'(OUT_DEPTH));
   end

   assign out_valid = (fifoCount_q != '0);
   assign out_data  = fifoData[rdPtr_q];
   assign out_last  = out_valid & fifoLast[rdPtr_q];

endmodule

// File: tb/tb_full_bias_add_ctrl.sv
// Self-checking bench for full_bias_add_ctrl: bias RAM and float adder models, scoreboard fed from
// the neuron index of each accepted word, vector table plus directed corner sequences.
module tb_full_bias_add_ctrl;

   localparam int CNT_W     = 10;
   localparam int OUT_DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset, start, in_valid, out_ready;
   logic [CNT_W-1:0] cfg_num_out;
   logic [31:0]      in_data;
   logic             busy, done, in_ready, bias_rd_en, out_valid, out_last;
   logic [CNT_W-1:0] bias_rd_addr;
   logic [31:0]      bias_rd_data = '0;
   logic [31:0]      add_a, add_b, out_data;
   logic [31:0]      add_result = '0;
`ifdef FULL_BIAS_BYPASS_EN
   logic             cfg_bypass = 1'b0;
`endif

   full_bias_add_ctrl #(.CNT_W(CNT_W), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_num_out(cfg_num_out),
`ifdef FULL_BIAS_BYPASS_EN
      .cfg_bypass(cfg_bypass),
`endif
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
      .add_a(add_a), .add_b(add_b), .add_result(add_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   typedef struct {
      int num;
      int pValid;
      int pReady;
      bit noStall;
   } vec_t;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] biasMem [0:1023];
   exp_t        expQ[$];
   int          cyc = 0, layerNum = 0, acceptIdx = 0, outCount = 0, lastCount = 0;
   int          doneCount = 0, stallCount = 0, biasRdCount = 0;
   int          firstAcceptCyc = -1, firstOutCyc = -1, lastPopCyc = -1, doneCyc = -1, startCyc = -1;
   bit          busySeen = 0, bypassMode = 0;
   logic [31:0] lastOutData = '0;
   logic        lastOutLast = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // IEEE single arithmetic done in double precision, truncated back to single.
   function automatic real spToReal(input logic [31:0] s);
      logic [63:0] d;
      if (s[30:23] == 8'h0) return 0.0;
      d[63]    = s[31];
      d[62:52] = 11'(s[30:23]) + 11'd896;
      d[51:0]  = {s[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] realToSp(input real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (d[62:52] == 11'h0 || e <= 0) return {d[63], 31'b0};
      if (e >= 255) return {d[63], 8'hFF, 23'b0};
      return {d[63], 8'(e), d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return realToSp(spToReal(a) + spToReal(b));
   endfunction

   function automatic logic [31:0] randFloat();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'(100 + $urandom_range(0, 50));
      return r;
   endfunction

   // Environment: synchronous bias RAM and the shared registered adder.
   always @(posedge clk) begin
      if (bias_rd_en) bias_rd_data <= biasMem[bias_rd_addr];
      add_result <= fadd(add_a, add_b);
   end

   // Scoreboard: expected value built from the neuron index of each accepted word.
   always @(negedge clk) begin
      exp_t e;
      bit   acc;
      cyc++;
      if (reset) begin
         expQ.delete();
      end else begin
         acc = in_valid && in_ready;
         if (start && startCyc < 0) startCyc = cyc;
         if (bias_rd_en) biasRdCount++;
         if (acc || bias_rd_en) checkOutput("bias_rd_en", bias_rd_en, acc && !bypassMode);
         if (acc) begin
            if (!bypassMode) checkOutput("bias_rd_addr", bias_rd_addr, acceptIdx);
            e.data = bypassMode ? in_data : fadd(in_data, biasMem[acceptIdx]);
            e.last = (acceptIdx == layerNum - 1);
            expQ.push_back(e);
            if (firstAcceptCyc < 0) firstAcceptCyc = cyc;
            acceptIdx++;
         end
         if (in_valid && !in_ready && busy && acceptIdx < layerNum) stallCount++;
         if (out_valid && firstOutCyc < 0) firstOutCyc = cyc;
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected output", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("out_data", out_data, e.data);
               checkOutput("out_last", out_last, e.last);
            end
            outCount++;
            if (out_last) lastCount++;
            lastOutData = out_data;
            lastOutLast = out_last;
            lastPopCyc  = cyc;
         end
         if (done) begin
            doneCount++;
            if (doneCyc < 0) doneCyc = cyc;
         end
         if (busy) busySeen = 1;
      end
   end

   task automatic startLayer(input int num, input bit byp);
      layerNum = num; acceptIdx = 0; outCount = 0; lastCount = 0; doneCount = 0;
      stallCount = 0; biasRdCount = 0; firstAcceptCyc = -1; firstOutCyc = -1;
      lastPopCyc = -1; doneCyc = -1; startCyc = -1; busySeen = 0; bypassMode = byp;
`ifdef FULL_BIAS_BYPASS_EN
      cfg_bypass = byp;
`endif
      start = 1'b1;
      cfg_num_out = CNT_W'(num);
      @(posedge clk); #1;
      start = 1'b0;
      cfg_num_out = CNT_W'($urandom);
`ifdef FULL_BIAS_BYPASS_EN
      cfg_bypass = ~byp;
`endif
   endtask

   task automatic applyStimulus(input int cycles, input int pValid, input int pReady,
                                input bit fixedEn, input logic [31:0] fixedVal, input bit untilDone);
      for (int c = 0; c < cycles; c++) begin
         if (untilDone && doneCount != 0) break;
         in_valid  = (acceptIdx < layerNum) && ($urandom_range(0, 99) < pValid);
         in_data   = fixedEn ? fixedVal : randFloat();
         out_ready = ($urandom_range(0, 99) < pReady);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic finishLayer(input string name, input int num);
      repeat (3) @(posedge clk);
      #1;
      checkOutput({name, " done pulses"}, doneCount, 1);
      checkOutput({name, " accepts"}, acceptIdx, num);
      checkOutput({name, " results"}, outCount, num);
      checkOutput({name, " last count"}, lastCount, (num > 0) ? 1 : 0);
      checkOutput({name, " scoreboard empty"}, expQ.size(), 0);
      checkOutput({name, " busy after done"}, busy, 0);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " busy"}, busy, 0);
      checkOutput({name, " done"}, done, 0);
      checkOutput({name, " in_ready"}, in_ready, 0);
      checkOutput({name, " bias_rd_en"}, bias_rd_en, 0);
      checkOutput({name, " out_valid"}, out_valid, 0);
      checkOutput({name, " out_last"}, out_last, 0);
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{num: 8,  pValid: 100, pReady: 100, noStall: 1'b1};
      vecs[1] = '{num: 1,  pValid: 100, pReady: 100, noStall: 1'b1};
      vecs[2] = '{num: 5,  pValid: 60,  pReady: 70,  noStall: 1'b0};
      vecs[3] = '{num: 12, pValid: 90,  pReady: 30,  noStall: 1'b0};
      vecs[4] = '{num: 20, pValid: 100, pReady: 50,  noStall: 1'b0};
      vecs[5] = '{num: 3,  pValid: 100, pReady: 100, noStall: 1'b1};
      for (int i = 0; i < 1024; i++) biasMem[i] = randFloat();

      reset = 1'b1; start = 1'b0; cfg_num_out = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // T1: single element with known operands and latency.
      biasMem[0] = 32'h3F000000;
      startLayer(1, 1'b0);
      applyStimulus(40, 100, 100, 1'b1, 32'h3F800000, 1'b1);
      checkOutput("T1 out_data", lastOutData, 32'h3FC00000);
      checkOutput("T1 out_last", lastOutLast, 1);
      checkOutput("T1 latency", firstOutCyc - firstAcceptCyc, 3);
      checkOutput("T1 done after pop", doneCyc - lastPopCyc, 1);
      finishLayer("T1", 1);

      // Vector table, including the back-to-back 8-element layer.
      for (int i = 0; i < 6; i++) begin
         startLayer(vecs[i].num, 1'b0);
         applyStimulus(vecs[i].num * 20 + 60, vecs[i].pValid, vecs[i].pReady, 1'b0, 32'h0, 1'b1);
         if (vecs[i].noStall) checkOutput($sformatf("vec%0d in_ready stalls", i), stallCount, 0);
         finishLayer($sformatf("vec%0d", i), vecs[i].num);
      end

      // T3: downstream blocked, only OUT_DEPTH words may be accepted.
      startLayer(16, 1'b0);
      applyStimulus(20, 100, 0, 1'b0, 32'h0, 1'b0);
      checkOutput("T3 accepts while blocked", acceptIdx, OUT_DEPTH);
      applyStimulus(400, 100, 100, 1'b0, 32'h0, 1'b1);
      finishLayer("T3", 16);

      // T4: empty layer.
      startLayer(0, 1'b0);
      applyStimulus(10, 100, 100, 1'b0, 32'h0, 1'b1);
      checkOutput("T4 done latency ok", (doneCyc >= startCyc) && (doneCyc - startCyc <= 2), 1);
      checkOutput("T4 busy seen", busySeen, 0);
      checkOutput("T4 bias reads", biasRdCount, 0);
      finishLayer("T4", 0);

      // T5: reset in the middle of a layer, then a clean layer.
      startLayer(10, 1'b0);
      for (int c = 0; c < 60 && acceptIdx < 5; c++) begin
         in_valid = 1'b1; in_data = randFloat(); out_ready = 1'b1;
         @(posedge clk); #1;
      end
      checkOutput("T5 accepts before reset", acceptIdx, 5);
      reset = 1'b1;
      @(posedge clk); #1;
      checkResetValues("T5 reset");
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      startLayer(3, 1'b0);
      applyStimulus(100, 100, 100, 1'b0, 32'h0, 1'b1);
      finishLayer("T5 restart", 3);

`ifdef FULL_BIAS_BYPASS_EN
      // T6: bypass mode carries in_data unchanged and never reads the RAM.
      startLayer(4, 1'b1);
      applyStimulus(100, 100, 100, 1'b1, 32'h40000000, 1'b1);
      checkOutput("T6 out_data", lastOutData, 32'h40000000);
      checkOutput("T6 bias reads", biasRdCount, 0);
      finishLayer("T6", 4);
      bypassMode = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
